// File: rtl/car_motion_ctrl.sv
// Per-frame player-car motion: steering, speed, road scroll and crash timing, updated once per vsync.
// Optional build macro CAR_MOTION_WRAP_EN makes steering wrap around the X_MIN..X_MAX range instead of clamping.
module car_motion_ctrl #(
  parameter int X_MIN        = 16,
  parameter int X_MAX        = 232,
  parameter int X_START      = 128,
  parameter int Y_POS        = 128,
  parameter int STEER_STEP   = 2,
  parameter int MAX_SPEED    = 12,
  parameter int ACCEL_FRAMES = 4,
  parameter int CRASH_FRAMES = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vsync,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_accel,
  input  logic        btn_brake,
  input  logic        collision,
  output logic [8:0]  player_x,
  output logic [8:0]  player_y,
  output logic [3:0]  speed,
  output logic [15:0] road_ofs,
  output logic        crashed,
  output logic        frame_tick
);

  localparam int ACW = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;

  localparam logic [9:0]     XMIN10    = 10'(X_MIN);
  localparam logic [9:0]     XMAX10    = 10'(X_MAX);
  localparam logic [9:0]     STEP10    = 10'(STEER_STEP);
  localparam logic [9:0]     RANGE10   = 10'(X_MAX - X_MIN + 1);
  localparam logic [8:0]     XSTART9   = 9'(X_START);
  localparam logic [8:0]     YPOS9     = 9'(Y_POS);
  localparam logic [3:0]     SPEED_MAX = 4'(MAX_SPEED);
  localparam logic [ACW-1:0] ACC_LAST  = ACW'(ACCEL_FRAMES - 1);
  localparam logic [7:0]     CRASH_CNT = 8'(CRASH_FRAMES);

  typedef enum logic {DRIVE = 1'b0, CRASH = 1'b1} state_t;

  state_t         state_q, state_d;
  logic           vsync_q, vsync_d;
  logic           armed_q, armed_d;
  logic           frame_tick_q, frame_tick_d;
  logic           coll_latch_q, coll_latch_d;
  logic [ACW-1:0] accel_cnt_q, accel_cnt_d;
  logic [7:0]     crash_cnt_q, crash_cnt_d;
  logic [8:0]     player_x_q, player_x_d;
  logic [8:0]     player_y_q, player_y_d;
  logic [3:0]     speed_q, speed_d;
  logic [15:0]    road_ofs_q, road_ofs_d;
  logic           crashed_q, crashed_d;

  logic [9:0] x10, x_left, x_right;

  // Candidate positions one steering step away, in 10 bits so the left move never underflows.
  always_comb begin
    x10 = {1'b0, player_x_q};
`ifdef CAR_MOTION_WRAP_EN
    x_left  = (x10 < XMIN10 + STEP10) ? x10 + RANGE10 - STEP10 : x10 - STEP10;
    x_right = (x10 + STEP10 > XMAX10) ? x10 + STEP10 - RANGE10 : x10 + STEP10;
`else
    x_left  = (x10 < XMIN10 + STEP10) ? XMIN10 : x10 - STEP10;
    x_right = (x10 + STEP10 > XMAX10) ? XMAX10 : x10 + STEP10;
`endif
  end

  always_comb begin
    state_d      = state_q;
    vsync_d      = vsync;
    armed_d      = armed_q | ~vsync;
    // armed_q suppresses a tick from a vsync that was already high when reset released.
    frame_tick_d = vsync & ~vsync_q & armed_q;
    coll_latch_d = coll_latch_q;
    accel_cnt_d  = accel_cnt_q;
    crash_cnt_d  = crash_cnt_q;
    player_x_d   = player_x_q;
    player_y_d   = YPOS9;
    speed_d      = speed_q;
    road_ofs_d   = road_ofs_q;
    crashed_d    = crashed_q;

    if (state_q == DRIVE && collision) begin
      coll_latch_d = 1'b1;
    end

    if (frame_tick_q) begin
      case (state_q)
        DRIVE: begin
          if (coll_latch_q) begin
            state_d      = CRASH;
            speed_d      = 4'd0;
            accel_cnt_d  = '0;
            crash_cnt_d  = CRASH_CNT;
            crashed_d    = 1'b1;
            coll_latch_d = 1'b0;
          end else begin
            if (btn_brake) begin
              speed_d     = (speed_q > 4'd2) ? speed_q - 4'd2 : 4'd0;
              accel_cnt_d = '0;
            end else if (btn_accel) begin
              if (accel_cnt_q == ACC_LAST) begin
                accel_cnt_d = '0;
                speed_d     = (speed_q >= SPEED_MAX) ? SPEED_MAX : speed_q + 4'd1;
              end else begin
                accel_cnt_d = accel_cnt_q + ACW'(1);
              end
            end else begin
              accel_cnt_d = '0;
            end

            if (speed_q != 4'd0 && (btn_left ^ btn_right)) begin
              player_x_d = btn_left ? x_left[8:0] : x_right[8:0];
            end

            road_ofs_d = road_ofs_q + {12'd0, speed_q};
          end
        end
        CRASH: begin
          crash_cnt_d = crash_cnt_q - 8'd1;
          if (crash_cnt_q == 8'd1) begin
            state_d      = DRIVE;
            crashed_d    = 1'b0;
            player_x_d   = XSTART9;
            coll_latch_d = 1'b0;
          end
        end
        default: state_d = DRIVE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= DRIVE;
      vsync_q      <= 1'b0;
      armed_q      <= 1'b0;
      frame_tick_q <= 1'b0;
      coll_latch_q <= 1'b0;
      accel_cnt_q  <= '0;
      crash_cnt_q  <= 8'd0;
      player_x_q   <= XSTART9;
      player_y_q   <= YPOS9;
      speed_q      <= 4'd0;
      road_ofs_q   <= 16'd0;
      crashed_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      vsync_q      <= vsync_d;
      armed_q      <= armed_d;
      frame_tick_q <= frame_tick_d;
      coll_latch_q <= coll_latch_d;
      accel_cnt_q  <= accel_cnt_d;
      crash_cnt_q  <= crash_cnt_d;
      player_x_q   <= player_x_d;
      player_y_q   <= player_y_d;
      speed_q      <= speed_d;
      road_ofs_q   <= road_ofs_d;
      crashed_q    <= crashed_d;
    end
  end

  assign player_x   = player_x_q;
  assign player_y   = player_y_q;
  assign speed      = speed_q;
  assign road_ofs   = road_ofs_q;
  assign crashed    = crashed_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_car_motion_ctrl.sv
// Bench for car_motion_ctrl: a vector table, hand-written corner sequences and randomized frames,
// all checked against a frame-level arithmetic model of the car.
module tb_car_motion_ctrl;
  localparam int X_MIN = 16, X_MAX = 232, X_START = 128, Y_POS = 128;
  localparam int STEP = 2, MAX_SPEED = 12, ACCEL_FRAMES = 4, CRASH_FRAMES = 60;

  logic clk = 1'b0;
  logic reset, vsync, btn_left, btn_right, btn_accel, btn_brake, collision;
  logic [8:0]  player_x, player_y;
  logic [3:0]  speed;
  logic [15:0] road_ofs;
  logic        crashed, frame_tick;

  car_motion_ctrl dut (
    .clk(clk), .reset(reset), .vsync(vsync),
    .btn_left(btn_left), .btn_right(btn_right), .btn_accel(btn_accel), .btn_brake(btn_brake),
    .collision(collision),
    .player_x(player_x), .player_y(player_y), .speed(speed), .road_ofs(road_ofs),
    .crashed(crashed), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, frame_no = 0;

  // Frame-level model of the car.
  int m_x, m_speed, m_ofs, m_acnt, m_crash_left;
  bit m_coll;

  typedef struct {
    bit l, r, a, b, c;
    int x, spd, ofs, crashed;
  } vec_t;
  vec_t tbl[8];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (frame %0d)", name, act, exp, frame_no);
  endtask

  task automatic model_reset();
    m_x = X_START; m_speed = 0; m_ofs = 0; m_acnt = 0; m_crash_left = 0; m_coll = 0;
  endtask

  function automatic int steer(input int x, input bit left);
    int nx;
    if (left) begin
      nx = x - STEP;
      if (nx < X_MIN) begin
`ifdef CAR_MOTION_WRAP_EN
        nx = X_MAX - (X_MIN - nx) + 1;
`else
        nx = X_MIN;
`endif
      end
    end else begin
      nx = x + STEP;
      if (nx > X_MAX) begin
`ifdef CAR_MOTION_WRAP_EN
        nx = X_MIN + (nx - X_MAX) - 1;
`else
        nx = X_MAX;
`endif
      end
    end
    return nx;
  endfunction

  task automatic model_frame(input bit l, input bit r, input bit a, input bit b);
    int ps;
    if (m_crash_left == 0) begin
      if (m_coll) begin
        m_crash_left = CRASH_FRAMES; m_speed = 0; m_acnt = 0; m_coll = 0;
      end else begin
        ps = m_speed;
        if (b) begin
          m_speed = (m_speed >= 2) ? m_speed - 2 : 0;
          m_acnt = 0;
        end else if (a) begin
          m_acnt++;
          if (m_acnt == ACCEL_FRAMES) begin
            m_acnt = 0;
            if (m_speed < MAX_SPEED) m_speed++;
          end
        end else m_acnt = 0;
        if (ps != 0 && (l != r)) m_x = steer(m_x, l);
        m_ofs = (m_ofs + ps) % 65536;
      end
    end else begin
      m_crash_left--;
      if (m_crash_left == 0) begin
        m_x = X_START; m_coll = 0;
      end
    end
  endtask

  task automatic check_model();
    check("player_x", int'(player_x), m_x);
    check("player_y", int'(player_y), Y_POS);
    check("speed", int'(speed), m_speed);
    check("road_ofs", int'(road_ofs), m_ofs);
    check("crashed", int'(crashed), (m_crash_left != 0) ? 1 : 0);
  endtask

  task automatic cyc(inout int ticks);
    @(negedge clk);
    if (frame_tick) ticks++;
  endtask

  // One frame: optional one-cycle collision pulse, vsync high for hi cycles then low for lo cycles.
  task automatic frame(input bit l, input bit r, input bit a, input bit b, input bit c,
                       input int hi, input int lo, input bit do_chk);
    int ticks = 0;
    btn_left = l; btn_right = r; btn_accel = a; btn_brake = b;
    if (c) begin
      collision = 1'b1;
      if (m_crash_left == 0) m_coll = 1;
      cyc(ticks);
      collision = 1'b0;
    end
    vsync = 1'b1;
    repeat (hi) cyc(ticks);
    vsync = 1'b0;
    repeat (lo) cyc(ticks);
    frame_no++;
    model_frame(l, r, a, b);
    if (do_chk) begin
      check("tick_count", ticks, 1);
      check_model();
      $display("frame %0d btn(l%0d r%0d a%0d b%0d) coll=%0d -> x=%0d spd=%0d ofs=%0d crashed=%0d",
               frame_no, l, r, a, b, c, player_x, speed, road_ofs, crashed);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_x"}, int'(player_x), 128);
    check({tag, "_y"}, int'(player_y), 128);
    check({tag, "_speed"}, int'(speed), 0);
    check({tag, "_ofs"}, int'(road_ofs), 0);
    check({tag, "_crashed"}, int'(crashed), 0);
    check({tag, "_tick"}, int'(frame_tick), 0);
  endtask

  initial begin
    int ticks, exp3[3], pre_ofs, x_hold, iter;

    // Eight frames of held accel from reset: speed steps once per four frames.
    for (int i = 0; i < 8; i++) begin
      tbl[i] = '{l: 0, r: 0, a: 1, b: 0, c: 0, x: 128, spd: (i + 1) / 4, ofs: 0, crashed: 0};
    end
    tbl[4].ofs = 1; tbl[5].ofs = 2; tbl[6].ofs = 3; tbl[7].ofs = 4;

    reset = 1'b0; vsync = 1'b0; collision = 1'b0;
    btn_left = 0; btn_right = 0; btn_accel = 0; btn_brake = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_values("por");

    // Release with vsync already high: no tick until vsync has been seen low.
    vsync = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    ticks = 0;
    repeat (10) cyc(ticks);
    vsync = 1'b0;
    repeat (3) cyc(ticks);
    check("rel_no_tick", ticks, 0);
    check_reset_values("rel");

    for (int i = 0; i < 8; i++) begin
      frame(tbl[i].l, tbl[i].r, tbl[i].a, tbl[i].b, tbl[i].c, 2, 3, 1);
      check("tbl_x", int'(player_x), tbl[i].x);
      check("tbl_speed", int'(speed), tbl[i].spd);
      check("tbl_ofs", int'(road_ofs), tbl[i].ofs);
      check("tbl_crashed", int'(crashed), tbl[i].crashed);
    end

    // Reach speed 5, then brake wins over accel.
    repeat (12) frame(0, 0, 1, 0, 0, 2, 2, 1);
    check("spd5", int'(speed), 5);
    check("ofs_at_spd5", int'(road_ofs), 40);
    exp3[0] = 3; exp3[1] = 1; exp3[2] = 0;
    for (int i = 0; i < 3; i++) begin
      frame(0, 0, 1, 1, 0, 1, 2, 1);
      check("brake_seq", int'(speed), exp3[i]);
    end
    for (int i = 0; i < 3; i++) begin
      frame(0, 0, 1, 0, 0, 1, 2, 1);
      check("accel_after_brake", int'(speed), 0);
    end
    check("ofs_after_brake", int'(road_ofs), 49);

    // Speed 1, then steer left down to x=18 and into the left boundary.
    frame(0, 0, 1, 0, 0, 1, 2, 1);
    check("spd1", int'(speed), 1);
    repeat (55) frame(1, 0, 0, 0, 0, 1, 1, 1);
    check("x18", int'(player_x), 18);
`ifdef CAR_MOTION_WRAP_EN
    exp3[0] = 16; exp3[1] = 231; exp3[2] = 229;
`else
    exp3[0] = 16; exp3[1] = 16; exp3[2] = 16;
`endif
    for (int i = 0; i < 3; i++) begin
      frame(1, 0, 0, 0, 0, 1, 2, 1);
      check("left_edge", int'(player_x), exp3[i]);
    end
    frame(1, 1, 0, 0, 0, 1, 2, 1);
    check("both_no_move", int'(player_x), exp3[2]);

    // Crash from speed 6; collision pulses during the crash must not extend it.
    iter = 0;
    while (m_speed != 6 && iter < 100) begin
      frame(0, 0, 1, 0, 0, 1, 2, 1);
      iter++;
    end
    check("spd6", int'(speed), 6);
    pre_ofs = int'(road_ofs);
    x_hold = int'(player_x);
    frame(0, 1, 1, 0, 1, 2, 2, 1);
    check("crash_enter", int'(crashed), 1);
    check("crash_speed", int'(speed), 0);
    check("crash_ofs_frozen", int'(road_ofs), pre_ofs);
    check("crash_x_frozen", int'(player_x), x_hold);
    for (int i = 0; i < CRASH_FRAMES - 1; i++) begin
      frame(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1, 1, 2, 1);
      check("crash_hold", int'(crashed), 1);
    end
    frame(0, 1, 1, 0, 1, 1, 2, 1);
    check("crash_exit", int'(crashed), 0);
    check("crash_exit_x", int'(player_x), 128);
    frame(0, 0, 1, 0, 0, 1, 2, 1);
    check("no_recrash", int'(crashed), 0);

    // Climb to MAX_SPEED, cruise until road_ofs is about to wrap, then check the wrap.
    iter = 0;
    while (m_speed < MAX_SPEED && iter < 200) begin
      frame(0, 0, 1, 0, 0, 1, 1, 0);
      iter++;
    end
    frame(0, 0, 1, 0, 0, 1, 1, 1);
    check("spd_ceiling", int'(speed), 12);
    iter = 0;
    while (m_ofs < 16'hFFF4 && iter < 8000) begin
      frame(0, 0, 0, 0, 0, 1, 1, (iter % 512) == 0);
      iter++;
    end
    check("reach_ofs_bound", (iter < 8000) ? 1 : 0, 1);
    pre_ofs = int'(road_ofs);
    frame(0, 0, 0, 0, 0, 1, 1, 1);
    check("ofs_wrap", int'(road_ofs), pre_ofs + 12 - 65536);

    // Randomized frames against the model.
    for (int i = 0; i < 150; i++) begin
      frame(1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 19) == 0), $urandom_range(1, 4), $urandom_range(1, 4), 1);
    end

    // Asynchronous reset in the middle of a frame.
    @(negedge clk);
    vsync = 1'b1;
    #2 reset = 1'b0;
    #1 check_reset_values("async_rst");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    model_reset();
    ticks = 0;
    repeat (10) cyc(ticks);
    vsync = 1'b0;
    repeat (2) cyc(ticks);
    check("rst2_no_tick", ticks, 0);
    check_reset_values("rst2");
    repeat (4) frame(0, 1, 1, 0, 0, 2, 2, 1);
    check("post_rst_speed", int'(speed), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
